// File: rtl/lbm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lbm_pkg
//  Description : Shared defaults, FSM encoding and channel slicing helper for
//                the LBM accelerator bank arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package lbm_pkg;

    // D2Q9 lattice defaults
    localparam int c_LBM_Q  = 9;
    localparam int c_LBM_DW = 16;
    localparam int c_LBM_AW = 12;

    // Bank swapper FSM encoding
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SWAP  = 2'd2
    } lbm_state_e;

    // Flattened multi-channel buses place channel ch at [chan_lo(ch, w) +: w]
    function automatic int chan_lo(input int ch, input int w);
        return ch * w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lbm_rd_return_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : lbm_rd_return_pipe
//  Description : RD_LAT-deep shift register carrying a read-issue flag and the
//                bank it was issued to, so returned data is steered from the
//                bank owned at issue time.
//  Revision    : 1.0  initial release
// ============================================================================
module lbm_rd_return_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_valid,
    input  logic i_sel,
    output logic o_valid,
    output logic o_sel
);

    logic [RD_LAT-1:0] r_valid_sr;
    logic [RD_LAT-1:0] r_sel_sr;

    // Shift {valid, bank_sel} one stage per cycle; reset discards in-flight reads
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_sr <= '0;
            r_sel_sr   <= '0;
        end else begin
            r_valid_sr[0] <= i_valid;
            r_sel_sr[0]   <= i_sel;
            for (int i = 1; i < RD_LAT; i++) begin
                r_valid_sr[i] <= r_valid_sr[i-1];
                r_sel_sr[i]   <= r_sel_sr[i-1];
            end
        end
    end

    assign o_valid = r_valid_sr[RD_LAT-1];
    assign o_sel   = r_sel_sr[RD_LAT-1];

endmodule
`default_nettype wire

// File: rtl/lbm_bank_swapper.sv
`default_nettype none
// ============================================================================
//  Module      : lbm_bank_swapper
//  Description : Ping-pong BRAM bank arbiter. Compute owns one bank while the
//                DDR transfer side owns the other; once both sides report chunk
//                completion, in-flight reads drain and ownership swaps.
//  Revision    : 1.0  initial release
// ============================================================================
module lbm_bank_swapper
    import lbm_pkg::*;
#(
    parameter int Q      = c_LBM_Q,
    parameter int DW     = c_LBM_DW,
    parameter int AW     = c_LBM_AW,
    parameter int RD_LAT = 1,
    parameter int CW     = 16
) (
    input  logic            m00_axis_aclk,
    input  logic            m00_axis_areset,
    // transfer side
    input  logic [AW-1:0]   xfer_addr,
    input  logic            xfer_wen,
    input  logic            xfer_ren,
    input  logic [Q*DW-1:0] xfer_wdata,
    output logic [Q*DW-1:0] xfer_rdata,
    output logic            xfer_rvalid,
    input  logic            xfer_done,
    output logic            xfer_grant,
    // compute side
    input  logic [Q*AW-1:0] cmp_addr,
    input  logic [Q-1:0]    cmp_wen,
    input  logic            cmp_ren,
    input  logic [Q*DW-1:0] cmp_wdata,
    output logic [Q*DW-1:0] cmp_rdata,
    output logic            cmp_rvalid,
    input  logic            cmp_done,
    output logic            cmp_grant,
    // banks
    output logic [Q*AW-1:0] bankA_addr,
    output logic [Q*AW-1:0] bankB_addr,
    output logic [Q-1:0]    bankA_wen,
    output logic [Q-1:0]    bankB_wen,
    output logic [Q*DW-1:0] bankA_wdata,
    output logic [Q*DW-1:0] bankB_wdata,
    input  logic [Q*DW-1:0] bankA_rdata,
    input  logic [Q*DW-1:0] bankB_rdata,
    // status
    output logic            cmp_bank,
    output logic            swap_pulse,
    output logic [CW-1:0]   swap_count
);

    localparam int c_CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [c_CNT_W-1:0] c_DRAIN_LAST = c_CNT_W'(RD_LAT - 1);

    lbm_state_e          r_state;
    logic                r_cmp_bank;
    logic                r_xfer_flag;
    logic                r_cmp_flag;
    logic                r_swap_pulse;
    logic [CW-1:0]       r_swap_count;
    logic [c_CNT_W-1:0]  r_drain_cnt;

    logic                w_run;
    logic                w_xfer_grant;
    logic                w_cmp_grant;
    logic                w_xfer_flag_nxt;
    logic                w_cmp_flag_nxt;
    logic [Q*AW-1:0]     w_xfer_addr_rep;
    logic [Q-1:0]        w_xfer_wen_g;
    logic [Q-1:0]        w_cmp_wen_g;
    logic                w_cmp_rv;
    logic                w_cmp_rsel;
    logic                w_xfer_rv;
    logic                w_xfer_rsel;

    assign w_run           = (r_state == ST_RUN);
    assign w_xfer_grant    = w_run & ~r_xfer_flag;
    assign w_cmp_grant     = w_run & ~r_cmp_flag;
    assign w_xfer_flag_nxt = r_xfer_flag | xfer_done;
    assign w_cmp_flag_nxt  = r_cmp_flag  | cmp_done;

    // Sticky done flags, drain countdown and the atomic ownership swap
    always_ff @(posedge m00_axis_aclk) begin
        if (m00_axis_areset) begin
            r_state      <= ST_RUN;
            r_cmp_bank   <= 1'b0;
            r_xfer_flag  <= 1'b0;
            r_cmp_flag   <= 1'b0;
            r_swap_pulse <= 1'b0;
            r_swap_count <= '0;
            r_drain_cnt  <= '0;
        end else begin
            r_swap_pulse <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    r_xfer_flag <= w_xfer_flag_nxt;
                    r_cmp_flag  <= w_cmp_flag_nxt;
                    if (w_xfer_flag_nxt && w_cmp_flag_nxt) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= '0;
                    end
                end
                ST_DRAIN: begin
                    // Ownership flips on the way into SWAP, after the last
                    // pre-swap read has had RD_LAT cycles to come back.
                    if (r_drain_cnt == c_DRAIN_LAST) begin
                        r_state      <= ST_SWAP;
                        r_cmp_bank   <= ~r_cmp_bank;
                        r_swap_pulse <= 1'b1;
                        r_swap_count <= r_swap_count + 1'b1;
                        r_xfer_flag  <= 1'b0;
                        r_cmp_flag   <= 1'b0;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                ST_SWAP: begin
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign w_xfer_addr_rep = {Q{xfer_addr}};
    assign w_xfer_wen_g    = {Q{xfer_wen & w_xfer_grant}};
    assign w_cmp_wen_g     = cmp_wen & {Q{w_cmp_grant}};

    // Route each side to the bank it currently owns; the two banks always
    // take opposite sources so neither is driven by both sides
    always_comb begin
        bankA_addr  = w_xfer_addr_rep;
        bankA_wen   = w_xfer_wen_g;
        bankA_wdata = xfer_wdata;
        bankB_addr  = w_xfer_addr_rep;
        bankB_wen   = w_xfer_wen_g;
        bankB_wdata = xfer_wdata;
        if (r_cmp_bank == 1'b0) begin
            bankA_addr  = cmp_addr;
            bankA_wen   = w_cmp_wen_g;
            bankA_wdata = cmp_wdata;
        end else begin
            bankB_addr  = cmp_addr;
            bankB_wen   = w_cmp_wen_g;
            bankB_wdata = cmp_wdata;
        end
    end

    lbm_rd_return_pipe #(
        .RD_LAT (RD_LAT)
    ) u_cmp_rd_pipe (
        .clk     (m00_axis_aclk),
        .rst     (m00_axis_areset),
        .i_valid (cmp_ren & w_cmp_grant),
        .i_sel   (r_cmp_bank),
        .o_valid (w_cmp_rv),
        .o_sel   (w_cmp_rsel)
    );

    lbm_rd_return_pipe #(
        .RD_LAT (RD_LAT)
    ) u_xfer_rd_pipe (
        .clk     (m00_axis_aclk),
        .rst     (m00_axis_areset),
        .i_valid (xfer_ren & w_xfer_grant),
        .i_sel   (~r_cmp_bank),
        .o_valid (w_xfer_rv),
        .o_sel   (w_xfer_rsel)
    );

    // Returned data comes from the bank recorded at issue; zero when idle
    always_comb begin
        cmp_rdata  = '0;
        xfer_rdata = '0;
        if (w_cmp_rv) begin
            cmp_rdata = w_cmp_rsel ? bankB_rdata : bankA_rdata;
        end
        if (w_xfer_rv) begin
            xfer_rdata = w_xfer_rsel ? bankB_rdata : bankA_rdata;
        end
    end

    assign cmp_rvalid  = w_cmp_rv;
    assign xfer_rvalid = w_xfer_rv;
    assign xfer_grant  = w_xfer_grant;
    assign cmp_grant   = w_cmp_grant;
    assign cmp_bank    = r_cmp_bank;
    assign swap_pulse  = r_swap_pulse;
    assign swap_count  = r_swap_count;

endmodule
`default_nettype wire

// File: tb/tb_lbm_bank_swapper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lbm_bank_swapper
//  Description : Directed self-checking bench for lbm_bank_swapper
//                (RD_LAT=2, CW=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lbm_bank_swapper;
    import lbm_pkg::*;

    localparam int Q      = 9;
    localparam int DW     = 16;
    localparam int AW     = 12;
    localparam int RD_LAT = 2;
    localparam int CW     = 4;

    localparam logic [Q*DW-1:0] c_A_DATA = {Q{16'hA5A0}};
    localparam logic [Q*DW-1:0] c_B_DATA = {Q{16'h5B5B}};

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   xfer_addr;
    logic            xfer_wen, xfer_ren, xfer_done;
    logic [Q*DW-1:0] xfer_wdata, xfer_rdata;
    logic            xfer_rvalid, xfer_grant;
    logic [Q*AW-1:0] cmp_addr;
    logic [Q-1:0]    cmp_wen;
    logic            cmp_ren, cmp_done;
    logic [Q*DW-1:0] cmp_wdata, cmp_rdata;
    logic            cmp_rvalid, cmp_grant;
    logic [Q*AW-1:0] bankA_addr, bankB_addr;
    logic [Q-1:0]    bankA_wen, bankB_wen;
    logic [Q*DW-1:0] bankA_wdata, bankB_wdata;
    logic [Q*DW-1:0] bankA_rdata, bankB_rdata;
    logic            cmp_bank, swap_pulse;
    logic [CW-1:0]   swap_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lbm_bank_swapper #(
        .Q(Q), .DW(DW), .AW(AW), .RD_LAT(RD_LAT), .CW(CW)
    ) dut (
        .m00_axis_aclk   (clk),
        .m00_axis_areset (rst),
        .xfer_addr       (xfer_addr),
        .xfer_wen        (xfer_wen),
        .xfer_ren        (xfer_ren),
        .xfer_wdata      (xfer_wdata),
        .xfer_rdata      (xfer_rdata),
        .xfer_rvalid     (xfer_rvalid),
        .xfer_done       (xfer_done),
        .xfer_grant      (xfer_grant),
        .cmp_addr        (cmp_addr),
        .cmp_wen         (cmp_wen),
        .cmp_ren         (cmp_ren),
        .cmp_wdata       (cmp_wdata),
        .cmp_rdata       (cmp_rdata),
        .cmp_rvalid      (cmp_rvalid),
        .cmp_done        (cmp_done),
        .cmp_grant       (cmp_grant),
        .bankA_addr      (bankA_addr),
        .bankB_addr      (bankB_addr),
        .bankA_wen       (bankA_wen),
        .bankB_wen       (bankB_wen),
        .bankA_wdata     (bankA_wdata),
        .bankB_wdata     (bankB_wdata),
        .bankA_rdata     (bankA_rdata),
        .bankB_rdata     (bankB_rdata),
        .cmp_bank        (cmp_bank),
        .swap_pulse      (swap_pulse),
        .swap_count      (swap_count)
    );

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_swap();
        logic seen;
        xfer_done = 1'b1;
        cmp_done  = 1'b1;
        tick();
        xfer_done = 1'b0;
        cmp_done  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            if (swap_pulse) seen = 1'b1;
            else tick();
        end
        chk("swap_seen", seen, 1'b1);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        xfer_addr   = '0;
        xfer_wen    = 1'b0;
        xfer_ren    = 1'b0;
        xfer_done   = 1'b0;
        xfer_wdata  = {Q{16'hCAFE}};
        cmp_addr    = '0;
        cmp_wen     = '0;
        cmp_ren     = 1'b0;
        cmp_done    = 1'b0;
        cmp_wdata   = '0;
        bankA_rdata = c_A_DATA;
        bankB_rdata = c_B_DATA;
        repeat (3) tick();
        rst = 1'b0;
        #1;

        // reset state
        chk("rst_cmp_bank",   cmp_bank,   1'b0);
        chk("rst_swap_count", swap_count, 4'd0);
        chk("rst_swap_pulse", swap_pulse, 1'b0);
        chk("rst_xfer_grant", xfer_grant, 1'b1);
        chk("rst_cmp_grant",  cmp_grant,  1'b1);
        chk("rst_cmp_rvalid", cmp_rvalid, 1'b0);
        chk("rst_cmp_rdata",  cmp_rdata,  '0);

        // compute write to ch0 lands in bank A, transfer write in bank B
        cmp_addr[chan_lo(0, AW) +: AW]   = 12'h010;
        cmp_wdata[chan_lo(0, DW) +: DW]  = 16'h1234;
        cmp_wen   = 9'h001;
        xfer_addr = 12'h3C5;
        xfer_wen  = 1'b1;
        #1;
        chk("wr_bankA_wen",   bankA_wen, 9'h001);
        chk("wr_bankA_addr0", bankA_addr[chan_lo(0, AW) +: AW], 12'h010);
        chk("wr_bankA_data0", bankA_wdata[chan_lo(0, DW) +: DW], 16'h1234);
        chk("wr_bankB_wen",   bankB_wen, 9'h1FF);
        chk("wr_bankB_addr",  bankB_addr, {Q{12'h3C5}});
        chk("wr_bankB_data",  bankB_wdata, {Q{16'hCAFE}});
        cmp_wen  = '0;
        xfer_wen = 1'b0;

        // reads return RD_LAT cycles later from the owned bank
        cmp_ren  = 1'b1;
        xfer_ren = 1'b1;
        tick();
        cmp_ren  = 1'b0;
        xfer_ren = 1'b0;
        #1;
        chk("rd_early_rvalid", cmp_rvalid, 1'b0);
        tick();
        chk("rd_cmp_rvalid",  cmp_rvalid,  1'b1);
        chk("rd_cmp_rdata",   cmp_rdata,   c_A_DATA);
        chk("rd_xfer_rvalid", xfer_rvalid, 1'b1);
        chk("rd_xfer_rdata",  xfer_rdata,  c_B_DATA);
        tick();
        chk("rd_after_rvalid", cmp_rvalid, 1'b0);
        chk("rd_after_rdata",  cmp_rdata,  '0);

        // both dones in one cycle with a compute read in flight
        xfer_done = 1'b1;
        cmp_done  = 1'b1;
        cmp_ren   = 1'b1;
        #1;
        chk("same_grant_issue", cmp_grant, 1'b1);
        tick();
        xfer_done = 1'b0;
        cmp_done  = 1'b0;
        cmp_ren   = 1'b0;
        #1;
        chk("same_drain_xgrant", xfer_grant, 1'b0);
        chk("same_drain_cgrant", cmp_grant,  1'b0);
        chk("same_drain_rv1",    cmp_rvalid, 1'b0);
        tick();
        chk("same_rvalid",      cmp_rvalid, 1'b1);
        chk("same_rdata_A",     cmp_rdata,  c_A_DATA);
        chk("same_pulse_early", swap_pulse, 1'b0);
        tick();
        chk("same_swap_pulse", swap_pulse, 1'b1);
        chk("same_cmp_bank",   cmp_bank,   1'b1);
        chk("same_swap_count", swap_count, 4'd1);
        chk("same_rvalid_off", cmp_rvalid, 1'b0);
        tick();
        chk("same_run_pulse", swap_pulse, 1'b0);
        chk("same_run_grant", cmp_grant,  1'b1);

        // after swap, compute writes go to bank B
        cmp_wen = 9'h001;
        #1;
        chk("swp_bankB_wen", bankB_wen, 9'h001);
        chk("swp_bankA_wen", bankA_wen, 9'h000);
        cmp_wen = '0;

        // staggered dones: transfer first, compute four cycles later
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
        #1;
        chk("stag_xfer_grant", xfer_grant, 1'b0);
        chk("stag_cmp_grant",  cmp_grant,  1'b1);
        repeat (3) tick();
        cmp_done = 1'b1;
        #1;
        chk("stag_cgrant_run", cmp_grant, 1'b1);
        tick();
        cmp_done = 1'b0;
        // accesses during DRAIN are dropped
        cmp_wen  = 9'h1FF;
        cmp_ren  = 1'b1;
        xfer_wen = 1'b1;
        #1;
        chk("drain_bankA_wen", bankA_wen, 9'h000);
        chk("drain_bankB_wen", bankB_wen, 9'h000);
        chk("drain_cmp_grant", cmp_grant, 1'b0);
        tick();
        chk("stag_pulse_early", swap_pulse, 1'b0);
        tick();
        cmp_wen  = '0;
        cmp_ren  = 1'b0;
        xfer_wen = 1'b0;
        #1;
        chk("stag_swap_pulse", swap_pulse, 1'b1);
        chk("stag_cmp_bank",   cmp_bank,   1'b0);
        chk("stag_swap_count", swap_count, 4'd2);
        chk("drain_no_rvalid", cmp_rvalid, 1'b0);
        tick();
        chk("drain_no_rvalid2", cmp_rvalid, 1'b0);
        chk("stag_run_xgrant",  xfer_grant, 1'b1);

        // reset during DRAIN discards the swap and in-flight reads
        xfer_done = 1'b1;
        cmp_done  = 1'b1;
        cmp_ren   = 1'b1;
        tick();
        xfer_done = 1'b0;
        cmp_done  = 1'b0;
        cmp_ren   = 1'b0;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rstd_swap_count", swap_count, 4'd0);
        chk("rstd_cmp_bank",   cmp_bank,   1'b0);
        chk("rstd_xfer_grant", xfer_grant, 1'b1);
        chk("rstd_cmp_grant",  cmp_grant,  1'b1);
        chk("rstd_rvalid",     cmp_rvalid, 1'b0);
        tick();
        chk("rstd_no_pulse", swap_pulse, 1'b0);
        chk("rstd_bank_hold", cmp_bank,  1'b0);

        // swap counter wraps modulo 2^CW
        for (int n = 0; n < 16; n++) do_swap();
        chk("wrap16_count", swap_count, 4'd0);
        chk("wrap16_bank",  cmp_bank,   1'b0);
        do_swap();
        chk("wrap17_count", swap_count, 4'd1);
        chk("wrap17_bank",  cmp_bank,   1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lbm_bank_swapper.md
Name: lbm_bank_swapper

Overview:
- Parametrised double-buffered (ping-pong) BRAM bank arbiter for the LBM accelerator.
- Two BRAM banks (A, B), each Q distribution channels wide. The LBM compute side owns one bank while the DDR transfer side fills or drains the other.
- When both sides signal completion of the current chunk, the block drains in-flight reads and swaps bank ownership atomically.
- Sits between the DDR transfer engine, the LBM solver and the per-direction BRAMs. It replaces the static single-bank port mux.

Parameters:
- Q, 9, number of distribution channels (D2Q9)
- DW, 16, data width per channel
- AW, 12, BRAM address width
- RD_LAT, 1, BRAM read latency in cycles (>=1)
- CW, 16, swap counter width

Ports:
- m00_axis_aclk  in  1  sole clock
- m00_axis_areset  in  1  synchronous, active-high reset
- xfer_addr  in  AW  transfer address, shared by all channels
- xfer_wen  in  1  transfer write, applied to all channels
- xfer_ren  in  1  transfer read request
- xfer_wdata  in  Q*DW  transfer write data, channel i at [i*DW +: DW]
- xfer_rdata  out  Q*DW  transfer read data
- xfer_rvalid  out  1  xfer_rdata valid
- xfer_done  in  1  pulse: transfer chunk complete
- xfer_grant  out  1  transfer side may issue accesses
- cmp_addr  in  Q*AW  per-channel compute addresses
- cmp_wen  in  Q  per-channel compute write enables
- cmp_ren  in  1  compute read request
- cmp_wdata  in  Q*DW  compute write data
- cmp_rdata  out  Q*DW  compute read data
- cmp_rvalid  out  1  cmp_rdata valid
- cmp_done  in  1  pulse: compute chunk complete
- cmp_grant  out  1  compute side may issue accesses
- bankA_addr, bankB_addr  out  Q*AW  bank addresses
- bankA_wen, bankB_wen  out  Q  bank write enables
- bankA_wdata, bankB_wdata  out  Q*DW  bank write data
- bankA_rdata, bankB_rdata  in  Q*DW  bank read data
- cmp_bank  out  1  0: compute owns A and transfer owns B; 1: the reverse
- swap_pulse  out  1  one-cycle pulse on each swap
- swap_count  out  CW  number of swaps, wraps modulo 2^CW

Behaviour:
- Reset values: state=RUN, cmp_bank=0, xfer_flag=0, cmp_flag=0, read pipelines cleared, swap_pulse=0, swap_count=0, rvalids=0, grants=1.
- Reset asserted mid-DRAIN or mid-SWAP: same result. In-flight rvalids are discarded; no swap occurs.
- FSM states: RUN, DRAIN, SWAP.
- RUN:
  - A done pulse sets its sticky flag.
  - A side's grant = (state==RUN) & !its_flag.
  - When both flags are set (including both done pulses in the same cycle), go to DRAIN on the next cycle.
- DRAIN:
  - Both grants are 0; bank wen is forced to 0.
  - A counter waits RD_LAT cycles so outstanding reads return on the pre-swap mapping, then go to SWAP.
- SWAP (one cycle):
  - cmp_bank toggles, swap_pulse=1, swap_count increments, both flags clear.
  - Next state is RUN.
- Done pulses arriving outside RUN, or while the side's flag is already set, are ignored.
- Port mapping is combinational from the registered cmp_bank:
  - The owned bank receives the owner's address, wen and wdata.
  - The transfer address is replicated to all Q channels.
  - xfer_wen is replicated to Q bits.
  - Each bank's wen is gated by its owner's grant.
- Accesses issued while the side's grant=0 have no effect: wen is dropped and no rvalid is generated.
- Read return:
  - rvalid = (ren & grant) delayed by exactly RD_LAT cycles.
  - The bank select is delayed alongside it, so rdata is taken from the bank that was owned at issue time.
  - rdata is 0 when rvalid=0.
- No bank is ever driven by both sides in the same cycle.
- swap_count wraps from 2^CW-1 to 0.

Decomposition:
- Shared package lbm_pkg holds:
  - Q, DW, AW defaults
  - FSM state encoding (RUN=2'd0, DRAIN=2'd1, SWAP=2'd2)
  - the channel slice helper convention
- One natural sub-module, lbm_rd_return_pipe: a RD_LAT-deep shift register of {valid, bank_sel}, instantiated once per side.

Test Plan:
- Reset, then compute writes cmp_addr ch0=12'h010 with data 16'h1234 → bankA_wen[0]=1, bankA_addr[11:0]=12'h010, bankB_wen=0; cmp_bank=0.
- xfer_done at cycle 5, cmp_done at cycle 9 → xfer_grant=0 from cycle 6; DRAIN at cycle 10; swap_pulse at cycle 10+RD_LAT; cmp_bank=1 and swap_count=1 afterwards.
- Both dones in the same cycle with RD_LAT=2, compute read issued that same cycle → cmp_rvalid 2 cycles later with bankA_rdata, even though the swap completes afterwards.
- cmp_wen=9'h1FF asserted during DRAIN → bankA_wen=bankB_wen=0, no rvalid.
- Reset asserted during DRAIN → cmp_bank=0, swap_count unchanged from reset value 0, both flags cleared, both grants=1 the next cycle.
- 2^CW+1 swap cycles with CW=4 → swap_count=1, cmp_bank=1.
